// File: rtl/rdata_return.sv
// Read-return path: registered memory read port, credit-bounded response FIFO, RDATA_PARITY_EN adds rdata_par.
// Latency: accept in T -> mem_rd in T+1 -> push in T+1+MEM_LATENCY -> rdata_valid in T+2+MEM_LATENCY.
// Backpressure: rdata_ready=0 holds the head; credits saturate at FIFO_DEPTH and raise rd_wait.
module rdata_return #(
   parameter int ADDR_WIDTH  = 11,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_LATENCY = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                  pll_clock,
   input  logic                  reset,
   input  logic                  rd_in,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   output logic                  rd_wait,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] rdata_out,
   output logic                  rdata_valid,
   input  logic                  rdata_ready
`ifdef RDATA_PARITY_EN
   ,
   output logic                  rdata_par
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   logic                   acc;
   logic                   push;
   logic                   pop;
   logic [CW-1:0]          credits_q, credits_d;
   logic [CW-1:0]          count_q, count_d;
   logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [MEM_LATENCY-1:0] vld_sr_q, vld_sr_d;
   logic [ADDR_WIDTH-1:0]  mem_addr_q;
   logic                   mem_rd_q;
   logic [DATA_WIDTH-1:0]  fifo_q [FIFO_DEPTH];

   // Credits count reads accepted but not yet popped, so pushes can never exceed FIFO space.
   assign rd_wait     = (credits_q == FULL_CNT);
   assign acc         = rd_in & ~rd_wait;
   assign push        = vld_sr_q[MEM_LATENCY-1];
   assign rdata_valid = (count_q != '0);
   assign pop         = rdata_valid & rdata_ready;
   assign rdata_out   = fifo_q[rd_ptr_q];
   assign mem_addr    = mem_addr_q;
   assign mem_rd      = mem_rd_q;

   always_comb begin
      credits_d = credits_q;
      case ({acc, pop})
         2'b10:   credits_d = credits_q + CW'(1);
         2'b01:   credits_d = credits_q - CW'(1);
         default: credits_d = credits_q;
      endcase
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Shift register mirrors the memory pipeline; its last stage marks valid mem_rdata.
   always_comb begin
      vld_sr_d    = vld_sr_q;
      vld_sr_d[0] = mem_rd_q;
      for (int i = 1; i < MEM_LATENCY; i++) begin
         vld_sr_d[i] = vld_sr_q[i-1];
      end
   end

   always_ff @(posedge pll_clock) begin
      if (reset) begin
         mem_rd_q   <= 1'b0;
         mem_addr_q <= '0;
         credits_q  <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         vld_sr_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         mem_rd_q  <= acc;
         if (acc) begin
            mem_addr_q <= addr_in;
         end
         credits_q <= credits_d;
         count_q   <= count_d;
         vld_sr_q  <= vld_sr_d;
         if (push) begin
            fifo_q[wr_ptr_q] <= mem_rdata;
            wr_ptr_q         <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
      end
   end

`ifdef RDATA_PARITY_EN
   logic par_q [FIFO_DEPTH];

   assign rdata_par = par_q[rd_ptr_q];

   always_ff @(posedge pll_clock) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            par_q[i] <= 1'b0;
         end
      end else if (push) begin
         par_q[wr_ptr_q] <= ^mem_rdata;
      end
   end
`endif

endmodule

// File: tb/tb_rdata_return.sv
// Bench for rdata_return: directed and random reads checked against a queue-based response model.
module tb_rdata_return;

   localparam int AW = 11;
   localparam int DW = 32;
   localparam int L  = 2;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          rd_in = 1'b0;
   logic [AW-1:0] addr_in = '0;
   logic          rd_wait;
   logic [AW-1:0] mem_addr;
   logic          mem_rd;
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] rdata_out;
   logic          rdata_valid;
   logic          rdata_ready = 1'b0;
`ifdef RDATA_PARITY_EN
   logic          rdata_par;
`endif

   always #5 clk = ~clk;

   rdata_return #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MEM_LATENCY(L),
      .FIFO_DEPTH (D)
   ) dut (
      .pll_clock  (clk),
      .reset      (reset),
      .rd_in      (rd_in),
      .addr_in    (addr_in),
      .rd_wait    (rd_wait),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_rdata  (mem_rdata),
      .rdata_out  (rdata_out),
      .rdata_valid(rdata_valid),
      .rdata_ready(rdata_ready)
`ifdef RDATA_PARITY_EN
      ,
      .rdata_par  (rdata_par)
`endif
   );

   // Memory model: data for the address presented with mem_rd appears L cycles later; junk otherwise.
   logic [DW-1:0] memarr [2048];
   logic [DW-1:0] pipe [L];

   always @(posedge clk) begin
      pipe[0] <= mem_rd ? memarr[mem_addr] : $urandom();
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
   end
   assign mem_rdata = pipe[L-1];

   typedef struct {
      logic [DW-1:0] data;
      int            rdy;
   } ent_t;

   ent_t          q[$];
   int            cyc;
   bit            prev_acc;
   logic [AW-1:0] last_addr;
   int            n_tests = 0;
   int            n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // The FIFO must never be pushed while full without a simultaneous pop.
   always @(negedge clk) begin
      if (!reset && dut.push && !dut.pop) begin
         n_tests++;
         assert (dut.count_q != 3'(D)) else begin
            n_fail++;
            $error("FAIL overflow observed=push_when_full expected=no_push");
         end
      end
   end

   task automatic step(input logic r, input logic [AW-1:0] a, input logic rdy, output bit acc_o);
      bit ev, pop;
      @(negedge clk);
      rd_in = r;
      addr_in = a;
      rdata_ready = rdy;
      #1;
      ev = (q.size() > 0) && (q[0].rdy <= cyc);
      chk("rdata_valid", rdata_valid, ev);
      if (ev) begin
         chk("rdata_out", rdata_out, q[0].data);
`ifdef RDATA_PARITY_EN
         chk("rdata_par", rdata_par, ^q[0].data);
`endif
      end
      chk("rd_wait", rd_wait, q.size() == D);
      chk("mem_rd", mem_rd, prev_acc);
      chk("mem_addr", mem_addr, last_addr);
      acc_o = r && (q.size() < D);
      pop = ev && rdy;
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (acc_o) begin
         q.push_back('{data: memarr[a], rdy: cyc + 2 + L});
         last_addr = a;
      end
      prev_acc = acc_o;
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      rd_in = 1'b0;
      rdata_ready = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_valid", rdata_valid, 1'b0);
      chk("rst_wait", rd_wait, 1'b0);
      chk("rst_mem_rd", mem_rd, 1'b0);
      chk("rst_mem_addr", mem_addr, '0);
      chk("rst_rdata", rdata_out, '0);
`ifdef RDATA_PARITY_EN
      chk("rst_par", rdata_par, 1'b0);
`endif
      q.delete();
      cyc = 0;
      prev_acc = 1'b0;
      last_addr = '0;
   endtask

   initial begin
      bit a;
      int k, budget;
      for (int i = 0; i < 2048; i++) memarr[i] = $urandom();
      memarr[11'h005] = 32'hDEADBEEF;
      memarr[11'h020] = 32'h00000007;
      memarr[11'h021] = 32'h00000003;

      // Reset state, then a single read returning DEADBEEF visible only in cycle 4.
      do_reset();
      step(1'b1, 11'h005, 1'b1, a);
      for (int i = 0; i < 7; i++) step(1'b0, 11'h000, 1'b1, a);

      // Streaming: 8 back-to-back reads with the consumer always ready.
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 11'(i), 1'b1, a);
      for (int i = 0; i < 6; i++) step(1'b0, 11'h000, 1'b1, a);

      // Backpressure: only 4 of 6 requests fit until the consumer drains.
      do_reset();
      k = 0;
      for (int c = 0; c < 8; c++) begin
         step(1'b1, 11'h010 + 11'(k), 1'b0, a);
         if (a) k++;
      end
      chk("bp_accept_count", 64'(k), 64'd4);
      budget = 0;
      while (k < 6 && budget < 40) begin
         step(1'b1, 11'h010 + 11'(k), 1'b1, a);
         if (a) k++;
         budget++;
      end
      chk("bp_resume_count", 64'(k), 64'd6);
      for (int i = 0; i < 8; i++) step(1'b0, 11'h000, 1'b1, a);

      // Mid-flight reset: three reads in flight are discarded, no stale output afterwards.
      for (int i = 0; i < 3; i++) step(1'b1, 11'h030 + 11'(i), 1'b1, a);
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b0, 11'h000, 1'b1, a);

`ifdef RDATA_PARITY_EN
      step(1'b1, 11'h020, 1'b1, a);
      step(1'b1, 11'h021, 1'b1, a);
      for (int i = 0; i < 6; i++) step(1'b0, 11'h000, 1'b1, a);
`endif

      // Random traffic with intermittent consumer stalls.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)),
              ($urandom_range(0, 9) < 7), a);
      end
      for (int i = 0; i < 10; i++) step(1'b0, 11'h000, 1'b1, a);
      chk("final_empty", rdata_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
